mdu_iter: RTL

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 64-bit `mul_unit`/`div_unit` pair with one shared datapath that has:
- configurable operand width and bits retired per cycle;
- a valid/ready request port and a tagged response;
- single-cycle fast paths for the divide special cases.

The execute stage drives `busy_o` into its stall logic and takes the result on `resp_valid_o`.

---
 rtl/mdu_iter_pkg.sv | 24 ++
 rtl/mdu_iter_if.sv | 28 ++
 rtl/mdu_iter_step.sv | 47 ++++
 rtl/mdu_iter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: RISC-V M-extension
// funct3 encoding, FSM states and the default retire rate.
package mdu_iter_pkg;

  localparam int MDU_STEP_BITS = 2;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage (master) and mdu_iter (slave).
interface mdu_iter_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             kill_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       op_i;
  logic             word_i;
  logic [XLEN-1:0]  src1_i;
  logic [XLEN-1:0]  src2_i;
  logic [TAG_W-1:0] tag_i;
  logic             resp_valid_o;
  logic [XLEN-1:0]  resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             busy_o;

  modport master (
    output kill_i, req_valid_i, op_i, word_i, src1_i, src2_i, tag_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
  );

  modport slave (
    input  kill_i, req_valid_i, op_i, word_i, src1_i, src2_i, tag_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
  );
endinterface

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath: STEP_BITS of shift-add (multiply)
// or STEP_BITS restoring compare/subtract stages (divide).
module mdu_iter_step #(
  parameter int XLEN      = 64,
  parameter int STEP_BITS = 2
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]             rem_t;
  logic [XLEN-1:0]           quo_t;
  logic [XLEN+STEP_BITS-1:0] sum_t;

  // Divide: hi = partial remainder, lo = dividend bits shifting out / quotient shifting in.
  // Multiply: hi = upper partial product, lo = multiplier shifting out / product low bits in.
  always_comb begin
    rem_t = {1'b0, hi_i};
    quo_t = lo_i;
    sum_t = {{STEP_BITS{1'b0}}, hi_i};
    hi_o  = hi_i;
    lo_o  = lo_i;
    if (div_i) begin
      for (int k = 0; k < STEP_BITS; k++) begin
        rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
        quo_t = {quo_t[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, opd_i}) begin
          rem_t    = rem_t - {1'b0, opd_i};
          quo_t[0] = 1'b1;
        end
      end
      hi_o = rem_t[XLEN-1:0];
      lo_o = quo_t;
    end else begin
      for (int k = 0; k < STEP_BITS; k++) begin
        if (lo_i[k]) sum_t = sum_t + ({{STEP_BITS{1'b0}}, opd_i} << k);
      end
      hi_o = sum_t[XLEN+STEP_BITS-1:STEP_BITS];
      lo_o = {sum_t[STEP_BITS-1:0], lo_i[XLEN-1:STEP_BITS]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: sign-magnitude capture, one shared step per
// cycle, sign fix-up on the FINISH load, single-cycle divide special cases.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int STEP_BITS = MDU_STEP_BITS,
  parameter int TAG_W     = 5
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  mdu_iter_if.slave  bus
);

  localparam int ITER_X = XLEN / STEP_BITS;
  localparam int ITER_W = 32 / STEP_BITS;
  localparam int CNT_W  = $clog2(ITER_X);

  function automatic logic [XLEN-1:0] wext(input logic [31:0] v, input logic sgn);
    return {{(XLEN-32){sgn & v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
  mdu_op_t          op_q, op_d;
  logic             word_q, word_d, neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  step_hi, step_lo;

  mdu_op_t         op_in;
  logic            div_in, rem_in, sgn1, sgn2, neg1, neg2, neg_in;
  logic            div0, ovf, special;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_v, spec_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem, calc_res;
  logic            ready_c, accept_c, busy_c, rvalid_c;

  mdu_iter_step #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_step (
    .div_i (op_q[2]),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .opd_i (opd_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  // Capture: extend, take magnitudes, detect the divide special cases.
  always_comb begin
    op_in  = mdu_op_t'(bus.op_i);
    div_in = bus.op_i[2];
    rem_in = (op_in == MDU_REM) || (op_in == MDU_REMU);
    sgn1   = (op_in == MDU_MUL) || (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
             (op_in == MDU_DIV) || (op_in == MDU_REM);
    sgn2   = (op_in == MDU_MUL) || (op_in == MDU_MULH) ||
             (op_in == MDU_DIV) || (op_in == MDU_REM);
    ext1   = bus.word_i ? wext(bus.src1_i[31:0], sgn1) : bus.src1_i;
    ext2   = bus.word_i ? wext(bus.src2_i[31:0], sgn2) : bus.src2_i;
    neg1   = sgn1 & ext1[XLEN-1];
    neg2   = sgn2 & ext2[XLEN-1];
    mag1   = neg1 ? -ext1 : ext1;
    mag2   = neg2 ? -ext2 : ext2;
    neg_in = (div_in && rem_in) ? neg1 : (neg1 ^ neg2);
    min_v  = bus.word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div0   = div_in && (ext2 == '0);
    ovf    = div_in && sgn2 && (ext1 == min_v) && (ext2 == '1);
    special  = div0 || ovf;
    spec_res = wfix(bus.word_i, div0 ? (rem_in ? ext1 : '1) : (rem_in ? '0 : ext1));
  end

  // Result of the final iteration, sign-corrected.
  always_comb begin
    prod = {step_hi, step_lo};
    if (word_q) prod = prod >> (XLEN - 32);
    if (neg_q)  prod = -prod;
    quo = neg_q ? -step_lo : step_lo;
    rem = neg_q ? -step_hi : step_hi;
    case (op_q)
      MDU_MUL:                        calc_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:
        calc_res = word_q ? {{(XLEN-32){1'b0}}, prod[63:32]} : prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              calc_res = quo;
      default:                        calc_res = rem;
    endcase
    calc_res = wfix(word_q, calc_res);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rtag_d   = rtag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    tag_d    = tag_q;
    ready_c  = 1'b0;
    rvalid_c = 1'b0;
    case (state_q)
      ST_IDLE: ready_c = 1'b1;
      ST_CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
          rdata_d = calc_res;
          rtag_d  = tag_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FINISH: begin
        ready_c  = 1'b1;
        rvalid_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    accept_c = bus.req_valid_i & ready_c & ~bus.kill_i;
    if (accept_c) begin
      op_d   = op_in;
      word_d = bus.word_i;
      neg_d  = neg_in;
      tag_d  = bus.tag_i;
      hi_d   = '0;
      cnt_d  = bus.word_i ? CNT_W'(ITER_W - 1) : CNT_W'(ITER_X - 1);
      if (div_in) begin
        lo_d  = bus.word_i ? (mag1 << (XLEN - 32)) : mag1;
        opd_d = mag2;
      end else begin
        lo_d  = mag2;
        opd_d = mag1;
      end
      if (special) begin
        state_d = ST_FINISH;
        rdata_d = spec_res;
        rtag_d  = bus.tag_i;
      end else begin
        state_d = ST_CALC;
      end
    end

    // Flush abandons everything, including a response about to be loaded.
    if (bus.kill_i) begin
      state_d  = ST_IDLE;
      rdata_d  = rdata_q;
      rtag_d   = rtag_q;
      rvalid_c = 1'b0;
    end
    busy_c = (accept_c || (state_q == ST_CALC)) && !bus.kill_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
    end
  end

  always_ff @(posedge clk_i) begin
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opd_q  <= opd_d;
    op_q   <= op_d;
    word_q <= word_d;
    neg_q  <= neg_d;
    tag_q  <= tag_d;
  end

  assign bus.req_ready_o  = ready_c;
  assign bus.resp_valid_o = rvalid_c;
  assign bus.resp_data_o  = rdata_q;
  assign bus.resp_tag_o   = rtag_q;
  assign bus.busy_o       = busy_c;

endmodule
